// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the program loader, PC and instruction ROM.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loader_state_t;

  localparam int LOADER_D = 12;
  localparam int LOADER_W = 9;

endpackage

// File: rtl/prog_loader_if.sv
// Host-to-loader word stream: valid/ready handshake carrying machine-code words.
interface prog_loader_if #(
  parameter int W = prog_loader_pkg::LOADER_W
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Streams host words sequentially into instruction memory from address 0,
// holding the core in reset until a complete program has been written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int D     = LOADER_D,
  parameter int W     = LOADER_W,
  parameter int DEPTH = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  prog_loader_if.slave   host,
  output logic           imem_wr_en,
  output logic [D-1:0]   imem_addr,
  output logic [W-1:0]   imem_wr_data,
  output logic           core_reset,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [D:0]     word_count,
  output logic [W-1:0]   checksum
);

  localparam logic [D-1:0] LAST_ADDR = D'(DEPTH - 1);

  loader_state_t state;
  logic [D-1:0]  addr;
  logic          accept;

  assign host.in_ready = (state == LOAD);
  assign accept        = host.in_valid && (state == LOAD);

  // The memory write port trails acceptance by one cycle, so the last word of
  // a program is written during the first DONE/ERR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      imem_wr_en   <= 1'b0;
      imem_addr    <= '0;
      imem_wr_data <= '0;
      core_reset   <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      word_count   <= '0;
      checksum     <= '0;
    end else begin
      imem_wr_en <= accept;
      if (accept) begin
        imem_addr    <= addr;
        imem_wr_data <= host.in_data;
      end

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LOAD;
            addr       <= '0;
            word_count <= '0;
            checksum   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b1;
            core_reset <= 1'b1;
          end
        end

        LOAD: begin
          if (accept) begin
            addr       <= addr + D'(1);
            word_count <= word_count + (D+1)'(1);
            checksum   <= checksum ^ host.in_data;
            // in_last on the final slot still counts as a complete program.
            if (host.in_last) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else if (addr == LAST_ADDR) begin
              state <= ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader using an 8-word memory (D = 3) so the
// overflow and wrap paths are reachable in a few cycles.
module tb_prog_loader;

  localparam int D     = 3;
  localparam int W     = 9;
  localparam int DEPTH = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         imem_wr_en;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_wr_data;
  logic         core_reset;
  logic         busy;
  logic         done;
  logic         err;
  logic [D:0]   word_count;
  logic [W-1:0] checksum;

  int compared   = 0;
  int mismatched = 0;

  prog_loader_if #(.W(W)) host_bus ();

  prog_loader #(.D(D), .W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .host         (host_bus.slave),
    .imem_wr_en   (imem_wr_en),
    .imem_addr    (imem_addr),
    .imem_wr_data (imem_wr_data),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .word_count   (word_count),
    .checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Idle for gap cycles (with a stray in_last to show it is ignored), then
  // present one word and check its write strobe one edge later.
  task automatic apply_stimulus(input logic [W-1:0] data, input logic last,
                                input logic [D-1:0] exp_addr, input int gap);
    for (int g = 0; g < gap; g++) begin
      host_bus.in_valid = 1'b0;
      host_bus.in_last  = (g == 0);
      tick();
      check_output("idle_no_write", imem_wr_en, 0);
    end
    host_bus.in_valid = 1'b1;
    host_bus.in_data  = data;
    host_bus.in_last  = last;
    check_output("ready_in_load", host_bus.in_ready, 1);
    tick();
    host_bus.in_valid = 1'b0;
    host_bus.in_last  = 1'b0;
    check_output("wr_en", imem_wr_en, 1);
    check_output("wr_addr", imem_addr, exp_addr);
    check_output("wr_data", imem_wr_data, data);
  endtask

  logic [W-1:0] prog [4];
  int           gaps [4];
  logic [W-1:0] exp_sum;
  logic [W-1:0] word;

  initial begin
    // 0x1A3 ^ 0x005 = 0x1A6; ^ 0x1FF = 0x059; ^ 0x040 = 0x019
    prog[0] = 9'h1A3; prog[1] = 9'h005; prog[2] = 9'h1FF; prog[3] = 9'h040;
    gaps[0] = 2;      gaps[1] = 0;      gaps[2] = 3;      gaps[3] = 1;

    reset             = 1'b1;
    start             = 1'b0;
    host_bus.in_valid = 1'b0;
    host_bus.in_data  = '0;
    host_bus.in_last  = 1'b0;
    tick();
    tick();
    $display("[TB] reset state");
    check_output("rst_core_reset", core_reset, 1);
    check_output("rst_in_ready", host_bus.in_ready, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_wr_en", imem_wr_en, 0);
    check_output("rst_word_count", word_count, 0);
    check_output("rst_checksum", checksum, 0);
    reset = 1'b0;
    tick();

    $display("[TB] reset in the middle of a load");
    pulse_start();
    check_output("load_busy", busy, 1);
    check_output("load_core_reset", core_reset, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(prog[i], 1'b0, D'(i), 0);
    check_output("mid_word_count", word_count, 3);
    reset = 1'b1;
    #1;
    check_output("async_word_count", word_count, 0);
    check_output("async_checksum", checksum, 0);
    check_output("async_in_ready", host_bus.in_ready, 0);
    check_output("async_core_reset", core_reset, 1);
    check_output("async_wr_en", imem_wr_en, 0);
    check_output("async_busy", busy, 0);
    tick();
    check_output("held_rst_wr_en", imem_wr_en, 0);
    reset = 1'b0;
    tick();
    check_output("idle_in_ready", host_bus.in_ready, 0);

    $display("[TB] back-to-back four-word program");
    pulse_start();
    for (int i = 0; i < 4; i++) apply_stimulus(prog[i], (i == 3), D'(i), 0);
    check_output("b2b_done", done, 1);
    check_output("b2b_core_reset", core_reset, 0);
    check_output("b2b_busy", busy, 0);
    check_output("b2b_in_ready", host_bus.in_ready, 0);
    check_output("b2b_word_count", word_count, 4);
    check_output("b2b_checksum", checksum, 9'h019);
    tick();
    check_output("b2b_single_strobe", imem_wr_en, 0);
    check_output("b2b_done_held", done, 1);

    $display("[TB] restart from DONE, gapped words, start ignored in LOAD");
    pulse_start();
    check_output("restart_core_reset", core_reset, 1);
    check_output("restart_done", done, 0);
    check_output("restart_word_count", word_count, 0);
    check_output("restart_checksum", checksum, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        pulse_start();
        check_output("start_in_load_busy", busy, 1);
        check_output("start_in_load_count", word_count, 2);
      end
      apply_stimulus(prog[i], (i == 3), D'(i), gaps[i]);
    end
    check_output("gap_done", done, 1);
    check_output("gap_word_count", word_count, 4);
    check_output("gap_checksum", checksum, 9'h019);

    $display("[TB] overflow: eight words without in_last");
    pulse_start();
    exp_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      word = W'(i * 19 + 5);
      exp_sum ^= word;
      apply_stimulus(word, 1'b0, D'(i), 0);
    end
    check_output("ovf_err", err, 1);
    check_output("ovf_done", done, 0);
    check_output("ovf_core_reset", core_reset, 1);
    check_output("ovf_busy", busy, 0);
    check_output("ovf_word_count", word_count, 8);
    check_output("ovf_checksum", checksum, exp_sum);
    host_bus.in_valid = 1'b1;
    host_bus.in_data  = 9'h0AA;
    check_output("ovf_in_ready", host_bus.in_ready, 0);
    tick();
    host_bus.in_valid = 1'b0;
    check_output("ovf_no_ninth_write", imem_wr_en, 0);
    check_output("ovf_count_held", word_count, 8);

    $display("[TB] full-depth program with in_last on the last slot");
    pulse_start();
    check_output("retry_err_clear", err, 0);
    exp_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      word = W'(i * 37 + 100);
      exp_sum ^= word;
      apply_stimulus(word, (i == DEPTH - 1), D'(i), 0);
    end
    check_output("full_done", done, 1);
    check_output("full_err", err, 0);
    check_output("full_core_reset", core_reset, 0);
    check_output("full_word_count", word_count, 8);
    check_output("full_checksum", checksum, exp_sum);

    $display("   *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
